// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot enable sequencer for a chain of NUM_STAGES datapath units, with per-stage hold, skip mask and abort.
// Latency: start edge to seq_done cycle = sum over enabled k of (hold_k+1), plus 1; all outputs registered.
// Backpressure: none; start is ignored (not queued) while RUN/FINISH. Optional macro SEQ_LOOP_EN adds multi-pass looping.
`timescale 1ns/1ps
module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int HOLD_W     = 4,
  parameter int IDX_W      = 4
) (
  input  logic                         clk_seq,
  input  logic                         rst_seq,
  input  logic                         start_seq,
  input  logic                         abort_seq,
  input  logic [NUM_STAGES-1:0]        stage_mask,
  input  logic [NUM_STAGES*HOLD_W-1:0] hold_cfg,
`ifdef SEQ_LOOP_EN
  input  logic [7:0]                   loop_num,
  output logic [7:0]                   loop_idx,
`endif
  output logic                         seq_busy,
  output logic                         seq_done,
  output logic                         seq_aborted,
  output logic [NUM_STAGES-1:0]        en_stage,
  output logic [IDX_W-1:0]             stage_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                         state_q, state_d;
  logic [NUM_STAGES-1:0]          mask_q, mask_d;
  logic [NUM_STAGES*HOLD_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]               cur_q, cur_d;
  logic [HOLD_W-1:0]              cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]          en_d;
  logic                           done_d, abrt_d;
  logic [IDX_W:0]                 hit;
`ifdef SEQ_LOOP_EN
  logic [7:0]                     loop_num_q, loop_num_d;
  logic [7:0]                     pass_q, pass_d;
`endif

  // Lowest set mask bit at or above lo; MSB of the result flags "found".
  function automatic logic [IDX_W:0] first_set(input logic [NUM_STAGES-1:0] m, input int lo);
    first_set = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (k >= lo && m[k]) first_set = {1'b1, IDX_W'(k)};
    end
  endfunction

  // Hold field of stage idx, selected by compare so no out-of-range index is formed.
  function automatic logic [HOLD_W-1:0] hold_of(input logic [NUM_STAGES*HOLD_W-1:0] h,
                                                input logic [IDX_W-1:0] idx);
    hold_of = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx == IDX_W'(k)) hold_of = h[k*HOLD_W +: HOLD_W];
    end
  endfunction

  // Next-state, stage walk and next-cycle output decode.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    hold_d  = hold_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abrt_d  = 1'b0;
    hit     = '0;
    en_d    = '0;
`ifdef SEQ_LOOP_EN
    loop_num_d = loop_num_q;
    pass_d     = pass_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_seq && !abort_seq) begin
          mask_d = stage_mask;
          hold_d = hold_cfg;
`ifdef SEQ_LOOP_EN
          loop_num_d = loop_num;
          pass_d     = 8'd0;
`endif
          hit = first_set(stage_mask, 0);
          if (hit[IDX_W]) begin
            state_d = S_RUN;
            cur_d   = hit[IDX_W-1:0];
            cnt_d   = hold_of(hold_cfg, hit[IDX_W-1:0]);
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_RUN: begin
        if (abort_seq) begin
          state_d = S_IDLE;
          abrt_d  = 1'b1;
          cur_d   = '0;
          cnt_d   = '0;
`ifdef SEQ_LOOP_EN
          pass_d  = 8'd0;
`endif
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else begin
          hit = first_set(mask_q, int'(cur_q) + 1);
          if (hit[IDX_W]) begin
            cur_d = hit[IDX_W-1:0];
            cnt_d = hold_of(hold_q, hit[IDX_W-1:0]);
`ifdef SEQ_LOOP_EN
          end else if (pass_q != loop_num_q) begin
            // Wrap straight to the first enabled stage of the next pass.
            hit    = first_set(mask_q, 0);
            pass_d = pass_q + 8'd1;
            cur_d  = hit[IDX_W-1:0];
            cnt_d  = hold_of(hold_q, hit[IDX_W-1:0]);
`endif
          end else begin
            state_d = S_FINISH;
            cur_d   = '0;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
`ifdef SEQ_LOOP_EN
        pass_d  = 8'd0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_FINISH);
    for (int k = 0; k < NUM_STAGES; k++) begin
      en_d[k] = (state_d == S_RUN) && (cur_d == IDX_W'(k));
    end
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk_seq) begin
    if (rst_seq) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      hold_q      <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
      en_stage    <= '0;
      stage_idx   <= '0;
      seq_busy    <= 1'b0;
      seq_done    <= 1'b0;
      seq_aborted <= 1'b0;
`ifdef SEQ_LOOP_EN
      loop_num_q  <= 8'd0;
      pass_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      hold_q      <= hold_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      en_stage    <= en_d;
      stage_idx   <= (state_d == S_RUN) ? cur_d : '0;
      seq_busy    <= (state_d == S_RUN);
      seq_done    <= done_d;
      seq_aborted <= abrt_d;
`ifdef SEQ_LOOP_EN
      loop_num_q  <= loop_num_d;
      pass_q      <= pass_d;
`endif
    end
  end

`ifdef SEQ_LOOP_EN
  assign loop_idx = pass_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: randomized and directed checks of stage_sequencer against a stage-list reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_stage_sequencer;

  logic        clk_seq = 1'b0;
  logic        rst_seq = 1'b1;
  logic        start_seq = 1'b0;
  logic        abort_seq = 1'b0;
  logic [4:0]  stage_mask = '0;
  logic [19:0] hold_cfg = '0;
  logic        seq_busy, seq_done, seq_aborted;
  logic [4:0]  en_stage;
  logic [3:0]  stage_idx;
`ifdef SEQ_LOOP_EN
  logic [7:0]  loop_num = '0;
  logic [7:0]  loop_idx;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_pass[$];

  stage_sequencer #(.NUM_STAGES(5), .HOLD_W(4), .IDX_W(4)) dut (
    .clk_seq    (clk_seq),
    .rst_seq    (rst_seq),
    .start_seq  (start_seq),
    .abort_seq  (abort_seq),
    .stage_mask (stage_mask),
    .hold_cfg   (hold_cfg),
`ifdef SEQ_LOOP_EN
    .loop_num   (loop_num),
    .loop_idx   (loop_idx),
`endif
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .seq_aborted(seq_aborted),
    .en_stage   (en_stage),
    .stage_idx  (stage_idx)
  );

  always #5 clk_seq = ~clk_seq;

  // Reference: list of active stage per cycle, one entry per enable cycle.
  function automatic void build_model(input logic [4:0] m, input logic [19:0] h, input int passes);
    exp_q.delete();
    exp_pass.delete();
    if (m == 5'd0) return;
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < 5; k++)
        if (m[k])
          for (int r = 0; r <= int'(h[k*4 +: 4]); r++) begin
            exp_q.push_back(k);
            exp_pass.push_back(p);
          end
  endfunction

  // Start one sequence and check every cycle until one idle cycle after it ends.
  task automatic run_seq(input logic [4:0] m, input logic [19:0] h, input int lnum,
                         input int abort_at, input logic [31:0] repulse, input string tag);
    int   len, endc;
    logic aborted;
    build_model(m, h, lnum + 1);
    len     = exp_q.size();
    aborted = (abort_at >= 1 && abort_at <= len);
    endc    = aborted ? abort_at + 1 : len + 1;
    stage_mask = m;
    hold_cfg   = h;
`ifdef SEQ_LOOP_EN
    loop_num   = 8'(lnum);
`endif
    start_seq  = 1'b1;
    abort_seq  = 1'b0;
    @(posedge clk_seq);
    #1;
    start_seq  = 1'b0;
    stage_mask = 5'($urandom);
    hold_cfg   = 20'($urandom);
`ifdef SEQ_LOOP_EN
    loop_num   = 8'($urandom);
`endif
    for (int c = 1; c <= endc + 1; c++) begin
      logic [4:0] e_en;
      logic [3:0] e_idx;
      logic       e_busy, e_done, e_ab;
      int         e_pass;
      @(negedge clk_seq);
      e_en = '0; e_idx = '0; e_busy = 1'b0; e_done = 1'b0; e_ab = 1'b0; e_pass = 0;
      if (c <= len && !(aborted && c > abort_at)) begin
        e_en   = 5'd1 << exp_q[c-1];
        e_idx  = 4'(exp_q[c-1]);
        e_busy = 1'b1;
        e_pass = exp_pass[c-1];
      end else if (aborted && c == abort_at + 1) begin
        e_ab = 1'b1;
      end else if (!aborted && c == len + 1) begin
        e_done = 1'b1;
      end
      n_cmp++;
      if (en_stage !== e_en) begin
        n_err++;
        $display("FAIL %s en_stage cycle %0d: got %b expected %b", tag, c, en_stage, e_en);
      end
      n_cmp++;
      if (stage_idx !== e_idx) begin
        n_err++;
        $display("FAIL %s stage_idx cycle %0d: got %0d expected %0d", tag, c, stage_idx, e_idx);
      end
      n_cmp++;
      if ({seq_busy, seq_done, seq_aborted} !== {e_busy, e_done, e_ab}) begin
        n_err++;
        $display("FAIL %s busy/done/aborted cycle %0d: got %b%b%b expected %b%b%b",
                 tag, c, seq_busy, seq_done, seq_aborted, e_busy, e_done, e_ab);
      end
`ifdef SEQ_LOOP_EN
      if (e_busy) begin
        n_cmp++;
        if (loop_idx !== 8'(e_pass)) begin
          n_err++;
          $display("FAIL %s loop_idx cycle %0d: got %0d expected %0d", tag, c, loop_idx, e_pass);
        end
      end
`endif
      start_seq = (c < 32) ? repulse[c] : 1'b0;
      abort_seq = (c == abort_at);
    end
    start_seq = 1'b0;
    abort_seq = 1'b0;
  endtask

  task automatic test_reset();
    rst_seq = 1'b1;
    repeat (2) @(posedge clk_seq);
    @(negedge clk_seq);
    n_cmp++;
    if ({en_stage, stage_idx, seq_busy, seq_done, seq_aborted} !== 12'd0) begin
      n_err++;
      $display("FAIL reset outputs: got %h expected 0", {en_stage, stage_idx, seq_busy, seq_done, seq_aborted});
    end
    rst_seq = 1'b0;
  endtask

  task automatic test_directed();
    run_seq(5'b11111, 20'h00000, 0, 0, 32'd0, "all_stages");
    run_seq(5'b10101, 20'h00200, 0, 0, 32'd0, "skip_hold");
    run_seq(5'b00000, 20'hFFFFF, 0, 0, 32'd0, "zero_mask");
    run_seq(5'b10001, 20'hFFFFF, 0, 0, 32'd0, "max_hold");
    run_seq(5'b01000, 20'h00000, 0, 0, 32'd0, "single_stage");
  endtask

  task automatic test_abort();
    run_seq(5'b11111, 20'h00000, 0, 3, 32'd0, "abort_run");
    run_seq(5'b11111, 20'h00000, 0, 0, 32'd0, "after_abort");
    run_seq(5'b11111, 20'h00000, 0, 6, 32'd0, "abort_finish");
  endtask

  task automatic test_restart_ignored();
    run_seq(5'b11111, 20'h00000, 0, 0, (32'd1 << 2) | (32'd1 << 6), "restart");
  endtask

  task automatic test_start_abort_same();
    stage_mask = 5'b11111;
    hold_cfg   = '0;
    start_seq  = 1'b1;
    abort_seq  = 1'b1;
    @(posedge clk_seq);
    #1;
    start_seq = 1'b0;
    abort_seq = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_seq);
      n_cmp++;
      if ({en_stage, stage_idx, seq_busy, seq_done, seq_aborted} !== 12'd0) begin
        n_err++;
        $display("FAIL start_abort cycle %0d: got %h expected 0", c,
                 {en_stage, stage_idx, seq_busy, seq_done, seq_aborted});
      end
    end
  endtask

  task automatic test_reset_midrun();
    stage_mask = 5'b11111;
    hold_cfg   = 20'h33333;
    start_seq  = 1'b1;
    @(posedge clk_seq);
    #1;
    start_seq = 1'b0;
    repeat (3) @(negedge clk_seq);
    n_cmp++;
    if (seq_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrun busy before reset: got %b expected 1", seq_busy);
    end
    rst_seq = 1'b1;
    @(negedge clk_seq);
    rst_seq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({en_stage, stage_idx, seq_busy, seq_done, seq_aborted} !== 12'd0) begin
        n_err++;
        $display("FAIL midrun reset cycle %0d: got %h expected 0", c,
                 {en_stage, stage_idx, seq_busy, seq_done, seq_aborted});
      end
      @(negedge clk_seq);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [4:0]  m;
      logic [19:0] h;
      int          lnum, ab;
      m = 5'($urandom);
      h = 20'($urandom);
`ifdef SEQ_LOOP_EN
      lnum = $urandom_range(0, 2);
`else
      lnum = 0;
`endif
      build_model(m, h, lnum + 1);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_q.size() + 1) : 0;
      run_seq(m, h, lnum, ab, 32'd0, "random");
    end
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    run_seq(5'b11111, 20'h00000, 2, 0, 32'd0, "loop3");
    run_seq(5'b00000, 20'h00000, 5, 0, 32'd0, "loop_zero_mask");
    run_seq(5'b00110, 20'h00010, 1, 5, 32'd0, "loop_abort");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_restart_ignored();
    test_start_abort_same();
    test_reset_midrun();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Parametrised one-hot stage sequencer. It drives the enable lines of a pipeline of NUM_STAGES datapath units, such as the abs/sub/abs/out chain of the error unit or the update stages of the FastICA iteration. Compared with the fixed five-state error controller, it adds:
- per-stage hold lengths
- a per-stage skip mask
- a start/busy/done handshake with abort
- an optional multi-pass loop

Parameters:
NUM_STAGES, 5, number of stage enables (1..16)
HOLD_W, 4, width of each per-stage hold-count field
IDX_W, 4, width of stage_idx output; must satisfy 2^IDX_W >= NUM_STAGES

Ports:
clk_seq  input  1  sequencer clock; single clock domain
rst_seq  input  1  synchronous, active-high reset
start_seq  input  1  start request, sampled on rising edge of clk_seq
abort_seq  input  1  abort request, sampled on rising edge of clk_seq
stage_mask  input  NUM_STAGES  bit k=1 runs stage k, 0 skips it; latched at start
hold_cfg  input  NUM_STAGES*HOLD_W  field k = extra cycles stage k is held; latched at start
seq_busy  output  1  high while a stage enable is asserted
seq_done  output  1  one-cycle pulse on normal completion
seq_aborted  output  1  one-cycle pulse after abort
en_stage  output  NUM_STAGES  one-hot (or zero) stage enables, registered
stage_idx  output  IDX_W  index of the active stage; 0 when idle

Behaviour:
- Reset: rst_seq high at an edge forces state IDLE and clears the latched mask, holds and counters. All outputs are 0. Reset applies in any state, including mid-sequence.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start_seq=1 and abort_seq=0 at edge T0: latch stage_mask and hold_cfg.
  - If the latched mask has any bit set: go to RUN at the lowest set stage. en_stage and seq_busy assert from cycle T0+1.
  - If the mask is all zero: go to FINISH; seq_done pulses in cycle T0+1; no enables assert.
  - start_seq and abort_seq both high: abort has priority; start is dropped; no seq_aborted pulse.
- RUN:
  - Exactly one en_stage bit is high. stage_idx equals its index. seq_busy=1.
  - Stage k stays active for hold_k+1 consecutive cycles; an internal counter counts down from hold_k.
  - When the counter expires, move to the next higher set mask bit with no gap cycle.
  - After the highest set bit expires, go to FINISH.
- FINISH: en_stage=0, seq_busy=0, seq_done=1 for exactly one cycle, then IDLE.
- Latency: start edge to done cycle = sum over enabled k of (hold_k+1), plus 1.
- Start while RUN or FINISH: ignored, with no queuing. Start in the FINISH cycle is also ignored.
- Abort in RUN at edge Ta:
  - State goes to IDLE.
  - In cycle Ta+1: en_stage=0, seq_busy=0, seq_aborted=1 for one cycle; seq_done is not pulsed.
- Abort in IDLE or FINISH: no effect; FINISH still completes with seq_done.
- Changes to stage_mask or hold_cfg during RUN: no effect on the current sequence.
- Hold count at maximum (2^HOLD_W-1) gives 2^HOLD_W cycles. No overflow or wrap is visible.
- Invariant: en_stage is never multi-hot.

Optional Feature:
Macro SEQ_LOOP_EN.
- Defined:
  - Adds input loop_num[7:0], latched at start, and output loop_idx[7:0].
  - The full masked sequence runs loop_num+1 times back-to-back. The last enabled stage of pass p is followed directly, with no gap cycle, by the first enabled stage of pass p+1.
  - loop_idx = current pass, 0-based, held at 0 in IDLE.
  - seq_done pulses only after the final pass. Abort ends all passes.
  - An all-zero mask still finishes immediately, regardless of loop_num.
- Undefined: ports absent; single pass, as described above.

Test Plan:
1. NUM_STAGES=5, mask=5'b11111, all holds 0, start at T0 -> en_stage = 00001,00010,00100,01000,10000 in cycles 1..5; seq_busy=1 in cycles 1..5; seq_done=1 in cycle 6 only.
2. mask=5'b10101, hold2=2, others 0 -> stage0 for 1 cycle, stage2 for 3 cycles, stage4 for 1 cycle; seq_done in cycle 6; stage_idx = 0,2,2,2,4.
3. mask=0, start -> seq_done in cycle 1; en_stage stays 0; seq_busy stays 0.
4. Case 1 with abort_seq at the edge ending cycle 3 -> en_stage=0 and seq_aborted=1 in cycle 4; no seq_done ever; a new start in cycle 5 runs normally.
5. start re-pulsed in cycles 2 and 6 of case 1; rst_seq pulsed mid-run in a separate run -> repeated starts ignored; reset drives all outputs 0 at the next cycle.
6. SEQ_LOOP_EN, loop_num=2, case-1 config -> 15 consecutive enable cycles; loop_idx = 0,1,2 over each 5-cycle pass; single seq_done in cycle 16.
